i2c_reg_master: RTL and testbench

I2C_REG_MASTER -- requirements
Module: i2c_reg_master

---
 rtl/i2c_reg_master.sv | 221 ++++++++++++++++++++++
 tb/tb_i2c_reg_master.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_master.sv
// I2C register master: single-byte register write, or pointer write
// followed by repeated START and single-byte read, quarter-slot SCL timing.
module i2c_reg_master #(
  parameter int CLK_DIV = 250,
  parameter int ADDR_W  = 7
) (
  input  logic              i_sys_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_rw,
  input  logic [ADDR_W-1:0] i_dev_addr,
  input  logic [7:0]        i_pointer,
  input  logic [7:0]        i_wdata,
  output logic [7:0]        o_rdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_nack,
  output logic              o_scl_oe,
  output logic              o_sda_oe,
  input  logic              i_sda
);

  localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ACK_A,
    S_PTR,
    S_ACK_P,
    S_WDATA,
    S_ACK_W,
    S_RSTART,
    S_ADDR_R,
    S_ACK_R,
    S_RDATA,
    S_MNACK,
    S_STOP,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [15:0]       r_div;
  logic [1:0]        r_q;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic [7:0]        r_rx;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_ptr;
  logic [7:0]        r_wdata;
  logic              r_nack_seen;
  logic              r_sda_m;
  logic              r_sda_s;

  state_t            w_nstate;
  logic [15:0]       w_ndiv;
  logic [1:0]        w_nq;
  logic [2:0]        w_nbit;
  logic [7:0]        w_nshift;
  logic              w_scl_n;
  logic              w_sda_n;
  logic              w_in_slot;
  logic              w_div_end;
  logic              w_slot_end;
  logic              w_sample;
  logic              w_last_bit;
  logic              w_ack_st;
  logic [7:0]        w_abyte_w;
  logic [7:0]        w_abyte_r;

  assign w_abyte_w  = 8'({r_addr, 1'b0});
  assign w_abyte_r  = 8'({r_addr, 1'b1});
  assign w_in_slot  = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_div_end  = (r_div == DIV_MAX);
  assign w_slot_end = w_div_end && (r_q == 2'd3);
  assign w_sample   = w_div_end && (r_q == 2'd1);
  assign w_last_bit = (r_bit == 3'd7);
  assign w_ack_st   = (r_state == S_ACK_A) || (r_state == S_ACK_P) ||
                      (r_state == S_ACK_W) || (r_state == S_ACK_R);

  // Next slot position and state; outputs are registered from these
  always_comb begin
    w_nstate = r_state;
    w_nbit   = r_bit;
    w_nshift = r_shift;
    w_ndiv   = 16'd0;
    w_nq     = 2'd0;
    if (w_in_slot) begin
      w_ndiv = w_div_end ? 16'd0 : r_div + 16'd1;
      w_nq   = w_div_end ? r_q + 2'd1 : r_q;
    end
    if (r_state == S_IDLE) begin
      if (i_start) w_nstate = S_START;
    end else if (r_state == S_DONE) begin
      w_nstate = S_IDLE;
    end else if (w_slot_end) begin
      w_nbit = 3'd0;
      unique case (r_state)
        S_START: begin
          w_nstate = S_ADDR;
          w_nshift = w_abyte_w;
        end
        S_RSTART: begin
          w_nstate = S_ADDR_R;
          w_nshift = w_abyte_r;
        end
        S_ADDR, S_PTR, S_WDATA, S_ADDR_R, S_RDATA: begin
          w_nshift = {r_shift[6:0], 1'b0};
          w_nbit   = r_bit + 3'd1;
          if (w_last_bit) begin
            case (r_state)
              S_ADDR:   w_nstate = S_ACK_A;
              S_PTR:    w_nstate = S_ACK_P;
              S_WDATA:  w_nstate = S_ACK_W;
              S_ADDR_R: w_nstate = S_ACK_R;
              default:  w_nstate = S_MNACK;
            endcase
          end
        end
        S_ACK_A: begin
          w_nstate = r_nack_seen ? S_STOP : S_PTR;
          w_nshift = r_ptr;
        end
        S_ACK_P: begin
          if (r_nack_seen) begin
            w_nstate = S_STOP;
          end else if (r_rw) begin
            w_nstate = S_RSTART;
          end else begin
            w_nstate = S_WDATA;
            w_nshift = r_wdata;
          end
        end
        S_ACK_R: w_nstate = r_nack_seen ? S_STOP : S_RDATA;
        S_ACK_W, S_MNACK: w_nstate = S_STOP;
        S_STOP: w_nstate = S_DONE;
        default: w_nstate = S_IDLE;
      endcase
    end
  end

  // Bus drive for the quarter being entered
  always_comb begin
    w_scl_n = 1'b0;
    w_sda_n = 1'b0;
    case (w_nstate)
      S_START, S_RSTART: begin
        w_scl_n = (w_nq == 2'd3);
        w_sda_n = w_nq[1];
      end
      S_STOP: begin
        w_scl_n = (w_nq == 2'd0);
        w_sda_n = ~w_nq[1];
      end
      S_ADDR, S_PTR, S_WDATA, S_ADDR_R: begin
        w_scl_n = (w_nq == 2'd0) || (w_nq == 2'd3);
        w_sda_n = ~w_nshift[7];
      end
      S_ACK_A, S_ACK_P, S_ACK_W, S_ACK_R, S_RDATA, S_MNACK:
        w_scl_n = (w_nq == 2'd0) || (w_nq == 2'd3);
      default: ;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_div       <= 16'd0;
      r_q         <= 2'd0;
      r_bit       <= 3'd0;
      r_shift     <= 8'h00;
      r_rx        <= 8'h00;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_ptr       <= 8'h00;
      r_wdata     <= 8'h00;
      r_nack_seen <= 1'b0;
      r_sda_m     <= 1'b1;
      r_sda_s     <= 1'b1;
      o_rdata     <= 8'h00;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_nack      <= 1'b0;
      o_scl_oe    <= 1'b0;
      o_sda_oe    <= 1'b0;
    end else begin
      r_sda_m  <= i_sda;
      r_sda_s  <= r_sda_m;
      r_state  <= w_nstate;
      r_div    <= w_ndiv;
      r_q      <= w_nq;
      r_bit    <= w_nbit;
      r_shift  <= w_nshift;
      o_scl_oe <= w_scl_n;
      o_sda_oe <= w_sda_n;
      o_done   <= 1'b0;
      if ((r_state == S_IDLE) && i_start) begin
        r_rw        <= i_rw;
        r_addr      <= i_dev_addr;
        r_ptr       <= i_pointer;
        r_wdata     <= i_wdata;
        r_nack_seen <= 1'b0;
        o_nack      <= 1'b0;
        o_busy      <= 1'b1;
      end
      if (w_sample) begin
        if (w_ack_st && r_sda_s) r_nack_seen <= 1'b1;
        if (r_state == S_RDATA) r_rx <= {r_rx[6:0], r_sda_s};
      end
      if ((r_state == S_STOP) && w_slot_end) begin
        o_done <= 1'b1;
        o_nack <= r_nack_seen;
        if (r_rw && !r_nack_seen) o_rdata <= r_rx;
      end
      if (r_state == S_DONE) o_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_reg_master.sv
// Bench for i2c_reg_master: open-drain bus model, responding target,
// bus-token scoreboard and a table of register transfers.
module tb_i2c_reg_master;

  localparam int TOK_S = 512;
  localparam int TOK_P = 768;
  localparam int NONE  = 9;

  typedef struct {
    bit         rw;
    logic [6:0] addr;
    logic [7:0] ptr;
    logic [7:0] wdata;
    logic [7:0] rdv;
    int         nidx;
    int         cyc;
    bit         nack;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       i_start = 1'b0;
  logic       i_rw = 1'b0;
  logic [6:0] i_dev_addr = '0;
  logic [7:0] i_pointer = '0;
  logic [7:0] i_wdata = '0;
  logic [7:0] o_rdata;
  logic       o_busy, o_done, o_nack, o_scl_oe, o_sda_oe;
  logic       sda_line;

  logic       tgt_pull = 1'b0;
  int         tgt_idx = 0;
  int         tgt_nack = NONE;
  logic [7:0] tgt_rd = 8'h00;

  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         exp_q[$];
  logic [7:0] last_rdata = 8'h00;
  vec_t       vt[8];
  vec_t       vm;

  assign sda_line = ~(o_sda_oe | tgt_pull);

  i2c_reg_master #(.CLK_DIV(4), .ADDR_W(7)) dut (
    .i_sys_clk (clk),
    .i_rst_n   (rst_n),
    .i_start   (i_start),
    .i_rw      (i_rw),
    .i_dev_addr(i_dev_addr),
    .i_pointer (i_pointer),
    .i_wdata   (i_wdata),
    .o_rdata   (o_rdata),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_nack    (o_nack),
    .o_scl_oe  (o_scl_oe),
    .o_sda_oe  (o_sda_oe),
    .i_sda     (sda_line)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_done) done_cnt++;

  // Bus monitor and target responder
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;
  int         m_bitn = 0;
  logic [7:0] m_sh = 8'h00;
  bit         m_first = 1'b0;
  bit         m_rdf = 1'b0;
  bit         m_addr_rd = 1'b0;

  always @(negedge clk) begin
    logic l_scl, l_sda;
    int   tok, e;
    bit   have;
    l_scl = ~o_scl_oe;
    l_sda = ~(o_sda_oe | tgt_pull);
    have  = 1'b0;
    tok   = 0;
    if (l_scl && p_scl && (l_sda != p_sda)) begin
      tok     = l_sda ? TOK_P : TOK_S;
      have    = 1'b1;
      m_bitn  = 0;
      m_first = 1'b1;
      m_rdf   = 1'b0;
    end else if (l_scl && !p_scl) begin
      if (m_bitn < 8) begin
        m_sh = {m_sh[6:0], l_sda};
        m_bitn++;
        if (m_bitn == 8) begin
          tok  = int'(m_sh);
          have = 1'b1;
          if (m_first) m_addr_rd = l_sda;
        end
      end else begin
        tok    = 256 + int'(l_sda);
        have   = 1'b1;
        m_bitn = 0;
        if (!m_rdf) tgt_idx++;
        if (m_first) m_rdf = m_addr_rd && !l_sda;
        else if (l_sda) m_rdf = 1'b0;
        m_first = 1'b0;
      end
    end else if (!l_scl && p_scl) begin
      if (m_bitn == 8) tgt_pull = !m_rdf && (tgt_idx != tgt_nack);
      else if (m_rdf) tgt_pull = ~tgt_rd[7-m_bitn];
      else tgt_pull = 1'b0;
    end
    p_scl = l_scl;
    p_sda = l_sda;
    if (have) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bus_token got %0h want none", tok);
      end else begin
        e = exp_q.pop_front();
        if (e != tok) begin
          errors++;
          $display("FAIL bus_token got %0h want %0h", tok, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run_xfer(input vec_t v, input bit rel_rst);
    int cyc;
    exp_q.push_back(TOK_S);
    exp_q.push_back(int'({v.addr, 1'b0}));
    exp_q.push_back(256 + int'(v.nidx == 0));
    if (v.nidx != 0) begin
      exp_q.push_back(int'(v.ptr));
      exp_q.push_back(256 + int'(v.nidx == 1));
      if (v.nidx > 1) begin
        if (!v.rw) begin
          exp_q.push_back(int'(v.wdata));
          exp_q.push_back(256 + int'(v.nidx == 2));
        end else begin
          exp_q.push_back(TOK_S);
          exp_q.push_back(int'({v.addr, 1'b1}));
          exp_q.push_back(256 + int'(v.nidx == 2));
          if (v.nidx > 2) begin
            exp_q.push_back(int'(v.rdv));
            exp_q.push_back(257);
          end
        end
      end
    end
    exp_q.push_back(TOK_P);
    tgt_idx  = 0;
    tgt_nack = v.nidx;
    tgt_rd   = v.rdv;
    @(negedge clk);
    if (rel_rst) rst_n = 1'b1;
    i_start    = 1'b1;
    i_rw       = v.rw;
    i_dev_addr = v.addr;
    i_pointer  = v.ptr;
    i_wdata    = v.wdata;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    i_start = 1'b0;
    chk("busy_on", int'(o_busy), 1);
    while (!o_done && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    if (!o_done) begin
      errors++;
      $display("FAIL done_timeout got %0d want %0d", cyc, v.cyc);
    end
    chk("cycles", cyc, v.cyc);
    chk("busy_in_done", int'(o_busy), 1);
    chk("nack", int'(o_nack), int'(v.nack));
    if (v.rw && !v.nack) last_rdata = v.rdv;
    chk("rdata", int'(o_rdata), int'(last_rdata));
    @(negedge clk);
    chk("done_pulse", int'(o_done), 0);
    chk("busy_off", int'(o_busy), 0);
    repeat (4) @(negedge clk);
    chk("busy_idle", int'(o_busy), 0);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    vt[0] = '{rw:0, addr:7'h50, ptr:8'h03, wdata:8'hA5, rdv:8'h00,
              nidx:NONE, cyc:465, nack:0};
    vt[1] = '{rw:1, addr:7'h50, ptr:8'h07, wdata:8'h00, rdv:8'h3C,
              nidx:NONE, cyc:625, nack:0};
    vt[2] = '{rw:1, addr:7'h50, ptr:8'h07, wdata:8'h00, rdv:8'hC3,
              nidx:0, cyc:177, nack:1};
    vt[3] = '{rw:0, addr:7'h1A, ptr:8'hC4, wdata:8'h5B, rdv:8'h00,
              nidx:1, cyc:321, nack:1};
    vt[4] = '{rw:0, addr:7'h7F, ptr:8'hFF, wdata:8'h00, rdv:8'h00,
              nidx:2, cyc:465, nack:1};
    vt[5] = '{rw:1, addr:7'h2D, ptr:8'h80, wdata:8'h00, rdv:8'h00,
              nidx:2, cyc:481, nack:1};
    vt[6] = '{rw:1, addr:7'h01, ptr:8'h00, wdata:8'h00, rdv:8'h81,
              nidx:NONE, cyc:625, nack:0};
    vt[7] = '{rw:0, addr:7'h00, ptr:8'h00, wdata:8'hFF, rdv:8'h00,
              nidx:NONE, cyc:465, nack:0};

    #1 rst_n = 1'b0;
    #1;
    chk("rst_scl", int'(o_scl_oe), 0);
    chk("rst_sda", int'(o_sda_oe), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_nack", int'(o_nack), 0);
    chk("rst_rdata", int'(o_rdata), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 8; k++) run_xfer(vt[k], 1'b0);

    // start pulsed mid-transfer with other inputs must be ignored
    vm = vt[0];
    fork
      run_xfer(vm, 1'b0);
      begin
        repeat (60) @(negedge clk);
        i_start    = 1'b1;
        i_rw       = 1'b1;
        i_dev_addr = 7'h21;
        i_pointer  = 8'h99;
        i_wdata    = 8'h11;
        @(negedge clk);
        i_start = 1'b0;
      end
    join

    // reset in the middle of the pointer byte
    exp_q.push_back(TOK_S);
    exp_q.push_back(32'hA0);
    exp_q.push_back(256);
    tgt_idx  = 0;
    tgt_nack = NONE;
    @(negedge clk);
    i_start    = 1'b1;
    i_rw       = 1'b0;
    i_dev_addr = 7'h50;
    i_pointer  = 8'h03;
    i_wdata    = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    repeat (177) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_scl", int'(o_scl_oe), 1);
    chk("pre_rst_busy", int'(o_busy), 1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_scl", int'(o_scl_oe), 0);
    chk("abort_sda", int'(o_sda_oe), 0);
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_rdata", int'(o_rdata), 0);
    last_rdata = 8'h00;
    repeat (5) @(negedge clk);
    chk("abort_nodone", done_cnt, d0);
    chk("abort_sb", exp_q.size(), 0);
    run_xfer(vt[0], 1'b1);
    run_xfer(vt[1], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
